// File: rtl/seven_seg_scanner_pkg.sv
// Shared 7-segment definitions: bit order, glyphs and scanner state type.
package seven_seg_scanner_pkg;

  // Segment vector bit order is {g,f,e,d,c,b,a}; bit 0 = segment a.
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  typedef logic [SEG_W-1:0]    seg_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Active-high glyphs.
  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h7C;
  localparam seg_t SEG_C   = 7'h39;
  localparam seg_t SEG_D   = 7'h5E;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_F   = 7'h71;
  localparam seg_t SEG_OFF = 7'h00;

  // Scanner control: INIT forces a snapshot on the first cycle out of reset.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scanner_seg7_decoder.sv
// Combinational nibble to active-high 7-segment decoder, hex capable.
module seven_seg_scanner_seg7_decoder
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Every nibble value maps to a visible glyph; nothing is hidden.
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment driver with frame snapshot, anode guard and
// leading-zero blanking.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned GUARD          = 2,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS*4-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int unsigned DATA_W = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Polarity masks applied only at the output registers.
  localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{ACTIVE_LOW_SEG}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW_AN}};

  scan_state_e             state_q, state_d;
  logic [PRE_W-1:0]        pre_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_W-1:0]       snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;

  logic                    slot_end_c;
  logic                    wrap_c;
  logic                    snap_load_c;
  logic [NUM_DIGITS-1:0]   blank_mask_c;
  logic                    higher_blank_c;
  nibble_t                 cur_nib_c;
  logic                    cur_dp_c;
  logic                    cur_blank_c;
  logic                    lit_c;
  logic [NUM_DIGITS-1:0]   an_c;
  seg_t                    seg_c;

  assign slot_end_c = (pre_q == PRE_LAST);
  assign wrap_c     = slot_end_c && (idx_q == IDX_LAST);

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and snapshot strobe: first cycle after reset, then each frame wrap.
  always_comb begin
    state_d     = state_q;
    snap_load_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d     = ST_RUN;
        snap_load_c = 1'b1;
      end
      ST_RUN: begin
        snap_load_c = wrap_c;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (slot_end_c) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Frame snapshot and its tick, so a whole frame shows one coherent sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      frame_tick    <= 1'b0;
    end else begin
      frame_tick <= snap_load_c;
      if (snap_load_c) begin
        snap_digits_q <= digits_in;
        snap_dp_q     <= dp_in;
      end
    end
  end

  // Leading-zero blanking: walk down from the top digit while zeros without dp.
  always_comb begin
    blank_mask_c   = '0;
    higher_blank_c = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      blank_mask_c[k] = BLANK_LEADING && higher_blank_c &&
                        (snap_digits_q[k*NIBBLE_W +: NIBBLE_W] == 4'h0) &&
                        !snap_dp_q[k];
      higher_blank_c  = blank_mask_c[k];
    end
  end

  // Select the current digit and build the one-hot anode enable.
  always_comb begin
    cur_nib_c   = '0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    an_c        = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib_c   = snap_digits_q[k*NIBBLE_W +: NIBBLE_W];
        cur_dp_c    = snap_dp_q[k];
        cur_blank_c = blank_mask_c[k];
      end
    end
    lit_c = (pre_q >= PRE_GUARD) && !cur_blank_c && !blank_en;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      an_c[k] = lit_c && (idx_q == IDX_W'(k));
    end
  end

  seven_seg_scanner_seg7_decoder u_decoder (
    .nibble (cur_nib_c),
    .seg    (seg_c)
  );

  // Output registers; segments keep showing the digit during guard so they settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_OFF ^ SEG_POL;
      dp_out  <= ACTIVE_LOW_SEG;
      an_out  <= AN_POL;
    end else begin
      seg_out <= seg_c ^ SEG_POL;
      dp_out  <= (cur_dp_c && lit_c) ^ ACTIVE_LOW_SEG;
      an_out  <= an_c ^ AN_POL;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner against a cycle-position model.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int FRAME = N * R;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: position counts clock edges since reset release.
  int          m_pos  = 0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_sdp  = '0;
  logic [12:0] exp_v;
  logic [12:0] act_v;

  seven_seg_scanner #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (R),
    .GUARD          (G),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1),
    .BLANK_LEADING  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_en   (blank_en),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  // Highest digit that must be shown: the top non-zero or dp-marked digit.
  function automatic int top_visible(input logic [15:0] d, input logic [3:0] p);
    for (int k = N - 1; k > 0; k--) begin
      if (d[k*4 +: 4] != 4'h0 || p[k]) return k;
    end
    return 0;
  endfunction

  // Advance one clock and compute the expected {an,seg,dp,tick}.
  task automatic tick();
    int          slot_pos;
    int          idx;
    logic        on;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    logic        ft_e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_pos  = 0;
      m_snap = '0;
      m_sdp  = '0;
      exp_v  = {4'hF, 7'h7F, 1'b1, 1'b0};
    end else begin
      slot_pos = m_pos % R;
      idx      = (m_pos / R) % N;
      on       = (idx <= top_visible(m_snap, m_sdp)) && (slot_pos >= G) && !blank_en;
      an_e     = on ? ~(4'b0001 << idx) : 4'hF;
      seg_e    = ~glyph(m_snap[idx*4 +: 4]);
      dp_e     = ~(on && m_sdp[idx]);
      m_pos    = m_pos + 1;
      ft_e     = (m_pos == 1) || (m_pos % FRAME == 0);
      if (ft_e) begin
        m_snap = digits_in;
        m_sdp  = dp_in;
      end
      exp_v = {an_e, seg_e, dp_e, ft_e};
    end
    act_v = {an_out, seg_out, dp_out, frame_tick};
  endtask

  task automatic test_reset();
    int ticks;
    rst = 1'b1; digits_in = 16'h0000; dp_in = 4'h0; blank_en = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (act_v !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, act_v, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frame_tick === 1'b1) ticks++;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
      if (i == 1) begin
        checks++;
        if (an_out !== 4'hE) begin
          errors++;
          $display("FAIL reset_first_anode cyc=%0d got=%h exp=e", cyc, an_out);
        end
      end
    end
    checks++;
    if (ticks != 1) begin
      errors++;
      $display("FAIL reset_tick_count got=%0d exp=1", ticks);
    end
  endtask

  task automatic test_scan();
    digits_in = 16'h1234; dp_in = 4'b0100;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL scan cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  task automatic test_blanking();
    digits_in = 16'h0005; dp_in = 4'b0000;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL blank_lead cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
      if (i >= FRAME) begin
        checks++;
        if (an_out !== 4'hF && an_out !== 4'hE) begin
          errors++;
          $display("FAIL blank_only_digit0 cyc=%0d got=%h exp=e_or_f", cyc, an_out);
        end
      end
    end
    dp_in = 4'b0010;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL blank_dp cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  task automatic test_tearing();
    int guard_cnt;
    digits_in = 16'h0999; dp_in = 4'b0000;
    guard_cnt = 0;
    while (m_pos % FRAME != 2 * R + 2 && guard_cnt < 4 * FRAME) begin
      tick();
      guard_cnt++;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL tear_pre cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
    digits_in = 16'h1000;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL tear_post cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  task automatic test_hex_blank_en();
    digits_in = 16'h00AF; dp_in = 4'b0000;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL hex cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
    blank_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v || an_out !== 4'hF) begin
        errors++;
        $display("FAIL blank_en cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
    blank_en = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL blank_en_release cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard_cnt;
    digits_in = 16'h5678; dp_in = 4'b0001;
    guard_cnt = 0;
    while (m_pos % FRAME != 3 * R + 1 && guard_cnt < 4 * FRAME) begin
      tick();
      guard_cnt++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (act_v !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, act_v, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    digits_in = 16'h4321; dp_in = 4'b1000;
    rst = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL mid_reset_resume cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        digits_in = 16'($urandom);
        if ($urandom_range(0, 1) == 0) digits_in[15:8] = 8'h00;
      end
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 11) == 0) blank_en = ~blank_en;
      rst = ($urandom_range(0, 150) == 0);
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
    rst = 1'b0;
    blank_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; digits_in = '0; dp_in = '0; blank_en = 1'b0;
    test_reset();
    test_scan();
    test_blanking();
    test_tearing();
    test_hex_blank_en();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed 7-segment display driver for the stopwatch digit chain.
- Consumes the packed BCD nibbles produced by the cascaded digit counters and drives one digit at a time on a shared segment bus.
- Sits between the counter chain and the board's anode/segment pins.
- Adds frame-synchronous snapshotting (no tearing), anode guard time (no ghosting) and leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_DIV, 100000, clk cycles per digit slot (>= GUARD+2)
GUARD, 2, cycles at start of each slot with all anodes inactive
ACTIVE_LOW_SEG, 1, 1 = segment/dp pins are active-low
ACTIVE_LOW_AN, 1, 1 = anode pins are active-low
BLANK_LEADING, 1, 1 = enable leading-zero blanking

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
digits_in  input  NUM_DIGITS*4  packed nibbles, digit 0 = [3:0] = least significant
dp_in  input  NUM_DIGITS  decimal point request per digit
blank_en  input  1  1 = whole display dark (sampled each cycle, no snapshot)
seg_out  output  7  segments {g,f,e,d,c,b,a}, registered
dp_out  output  1  decimal point, registered
an_out  output  NUM_DIGITS  one-hot digit select, registered
frame_tick  output  1  one-cycle pulse when digit index wraps to 0

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - Prescaler = 0, digit index = 0, snapshot = 0, frame_tick = 0.
  - an_out, seg_out and dp_out all at their inactive level (an_out all-1 and seg_out 7'h7F when the active-low parameters = 1).
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the index advances modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
- Snapshot:
  - digits_in and dp_in are captured into an internal register on the cycle the index wraps to 0, and also on the first cycle after reset release.
  - All digits of a frame therefore come from the same sample.
  - frame_tick pulses high on that same cycle.
- Output latency: seg/dp/an are registered from index, prescaler and snapshot; 1 cycle after the internal index changes.
- Guard: while prescaler < GUARD, an_out is all-inactive. seg_out still shows the new digit so the segment lines settle before the anode turns on.
- Anode: for prescaler >= GUARD, only an_out[index] is active, provided the digit is not blanked.
- Decode (shared decoder):
  - 0-9 use standard glyphs; 0 = 7'b0111111 active-high.
  - 10-15 show hex A,b,C,d,E,F. Out-of-range values are visible, never hidden.
- Leading-zero blanking (BLANK_LEADING=1):
  - Scanning from digit NUM_DIGITS-1 down, digit k is blanked iff its nibble == 0, its dp == 0, and every higher digit is also blanked.
  - Digit 0 is never blanked.
  - A blanked digit drives its anode inactive for the whole slot.
- blank_en=1: all anodes inactive from the next cycle. The prescaler, index and snapshot keep running, so scan phase is preserved.
- dp_out reflects the snapshot dp for the current index and is gated by the same anode enable.
- Reset mid-frame: returns to index 0 and prescaler 0 on the next edge; outputs go inactive that edge. The first frame after reset begins with a fresh snapshot.
- Polarity parameters invert only at the output register; internal logic is active-high.

Decomposition:
- Shared header (stopwatch_defs):
  - 7-segment glyph localparams SEG_0..SEG_F (active-high {g..a}).
  - SEG_OFF.
  - Segment bit-order definition.
- Sub-module seg7_decoder: combinational 4-bit nibble -> 7-bit active-high segments. It is reusable by other display paths.
- Prescaler, index, snapshot, blanking and output registers stay in seven_seg_scanner.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1 and active-low outputs.
1. Reset: hold rst 3 cycles -> an_out=4'hF, seg_out=7'h7F, dp_out=1, frame_tick=0. Release -> frame_tick pulses once; an_out=4'hE from the 2nd cycle of slot 0.
2. Scan: digits_in=16'h1234, dp_in=4'b0100 -> per slot, after guard:
   - an=E seg=~SEG_4
   - an=D seg=~SEG_3
   - an=B seg=~SEG_2 dp_out=0
   - an=7 seg=~SEG_1
   - Repeats every 16 cycles, and an=F during the guard cycle of each slot.
3. Blanking: digits_in=16'h0005, dp_in=0 -> only an[0] ever asserted, seg=~SEG_5. digits_in=16'h0005, dp_in=4'b0010 -> digits 1 and 0 shown ("0.5"), digits 3 and 2 dark.
4. Tearing: change digits_in from 16'h0999 to 16'h1000 in the middle of slot 2 -> the rest of that frame still shows 0999 (digit 3 blanked). The next frame shows 1000, switching exactly at frame_tick.
5. Hex/blank_en: digits_in=16'h00AF -> seg ~SEG_F then ~SEG_A. Assert blank_en for 5 cycles -> an=F throughout, frame_tick cadence unchanged.
6. Mid-frame reset in slot 3 -> next cycle all outputs inactive. After release, slot 0 displays with a fresh snapshot.
